// File: rtl/div_seq_param_if.sv
// div_seq_param_if: operand/result bundle and start/done handshake
// for the sequential divider; master drives requests, slave answers.
interface div_seq_param_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quot, rem, busy, done, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quot, rem, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_seq_param.sv
// div_seq_param: WIDTH-bit restoring divider, one quotient bit per cycle.
// Signed mode is built only when DIV_SIGNED_EN is defined.
module div_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  div_seq_param_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // dvd shifts dividend bits out at the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] trial;

  // operand sign capture and magnitude formation
  always_comb begin
`ifdef DIV_SIGNED_EN
    sgn = bus.signed_op;
`else
    sgn = bus.signed_op & 1'b0;
`endif
    a_neg = sgn & bus.dividend[WIDTH-1];
    b_neg = sgn & bus.divisor[WIDTH-1];
    a_mag = a_neg ? -bus.dividend : bus.dividend;
    b_mag = b_neg ? -bus.divisor : bus.divisor;
  end

  // one restoring step; remainder < divisor, so trial fits WIDTH bits
  always_comb begin
    shifted = {part_q, dvd_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dsr_q};
    trial   = shifted[WIDTH-1:0] - dsr_q;
  end

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    part_d  = part_q;
    orig_d  = orig_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = a_mag;
          dsr_d   = b_mag;
          orig_d  = bus.dividend;
          part_d  = '0;
          cnt_d   = '0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          zero_d  = (bus.divisor == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        part_d = ge ? trial : shifted[WIDTH-1:0];
        dvd_d  = {dvd_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        done_d  = 1'b1;
        dbz_d   = zero_q;
        state_d = IDLE;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = orig_q;
        end else begin
          // MIN / -1 falls out naturally: -(2^(W-1)) wraps to MIN
          quot_d = qneg_q ? -dvd_q : dvd_q;
          rem_d  = rneg_q ? -part_q : part_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      part_q  <= '0;
      orig_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      part_q  <= part_d;
      orig_q  <= orig_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: directed and reference-model checks of div_seq_param
// at WIDTH 16, plus random operands at WIDTH 8 and 32.
module tb_div_seq_param;
`ifdef DIV_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_param_if #(.WIDTH(16)) b16 ();
  div_seq_param_if #(.WIDTH(8))  b8 ();
  div_seq_param_if #(.WIDTH(32)) b32 ();

  div_seq_param #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  div_seq_param #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  div_seq_param #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

  int total = 0;
  int bad = 0;

  logic [63:0] oq, orr;
  logic        odz;
  int          olat;

  task automatic drive(input int w, input logic st, input logic s,
                       input logic [63:0] a, input logic [63:0] b);
    case (w)
      8: begin
        b8.start = st; b8.signed_op = s;
        b8.dividend = a[7:0]; b8.divisor = b[7:0];
      end
      32: begin
        b32.start = st; b32.signed_op = s;
        b32.dividend = a[31:0]; b32.divisor = b[31:0];
      end
      default: begin
        b16.start = st; b16.signed_op = s;
        b16.dividend = a[15:0]; b16.divisor = b[15:0];
      end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      8:       return b8.done;
      32:      return b32.done;
      default: return b16.done;
    endcase
  endfunction

  // one operation; lat = edges after the start edge until done is seen
  task automatic run(input int w, input logic [63:0] a,
                     input logic [63:0] b, input logic s,
                     output logic [63:0] q, output logic [63:0] r,
                     output logic dz, output int lat);
    @(negedge clk);
    drive(w, 1'b1, s, a, b);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) drive(w, 1'b0, s, a, b);
      if (get_done(w) === 1'b1) begin
        lat = k;
        break;
      end
    end
    case (w)
      8: begin
        q = 64'(b8.quot); r = 64'(b8.rem); dz = b8.div_by_zero;
      end
      32: begin
        q = 64'(b32.quot); r = 64'(b32.rem); dz = b32.div_by_zero;
      end
      default: begin
        q = 64'(b16.quot); r = 64'(b16.rem); dz = b16.div_by_zero;
      end
    endcase
  endtask

  function automatic void ref_div(input int w, input logic [63:0] a,
                                  input logic [63:0] b, input logic s,
                                  output logic [63:0] q,
                                  output logic [63:0] r,
                                  output logic dz);
    logic [63:0] m;
    longint sa, sb;
    m = (64'd1 << w) - 64'd1;
    dz = (b == 64'd0);
    if (dz) begin
      q = m;
      r = a;
    end else if (s && SEN) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
      q = 64'(sa / sb) & m;
      r = 64'(sa % sb) & m;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(16, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    total += 5;
    if (b16.quot !== 16'd0) begin
      bad++; $display("FAIL reset_quot got=%h exp=0", b16.quot);
    end
    if (b16.rem !== 16'd0) begin
      bad++; $display("FAIL reset_rem got=%h exp=0", b16.rem);
    end
    if (b16.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b exp=0", b16.busy);
    end
    if (b16.done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b exp=0", b16.done);
    end
    if (b16.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_dbz got=%b exp=0", b16.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive(16, 1'b1, 1'b0, 64'd100, 64'd7);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 0) b16.start = 1'b0;
      total++;
      if (b16.busy !== 1'b1 || b16.done !== 1'b0) begin
        bad++;
        $display("FAIL basic_busy k=%0d busy=%b done=%b exp 1/0",
                 k, b16.busy, b16.done);
      end
    end
    @(negedge clk);
    total += 5;
    if (b16.done !== 1'b1) begin
      bad++; $display("FAIL basic_done got=%b exp=1", b16.done);
    end
    if (b16.busy !== 1'b0) begin
      bad++; $display("FAIL basic_busy_end got=%b exp=0", b16.busy);
    end
    if (b16.quot !== 16'd14) begin
      bad++; $display("FAIL basic_quot got=%0d exp=14", b16.quot);
    end
    if (b16.rem !== 16'd2) begin
      bad++; $display("FAIL basic_rem got=%0d exp=2", b16.rem);
    end
    if (b16.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_dbz got=%b exp=0", b16.div_by_zero);
    end
    @(negedge clk);
    total += 2;
    if (b16.done !== 1'b0) begin
      bad++; $display("FAIL basic_pulse got=%b exp=0", b16.done);
    end
    if (b16.quot !== 16'd14) begin
      bad++; $display("FAIL basic_hold got=%0d exp=14", b16.quot);
    end
  endtask

  task automatic check16(input string nm, input logic [63:0] eq,
                         input logic [63:0] er, input logic edz);
    total += 4;
    if (oq !== eq) begin
      bad++; $display("FAIL %s_quot got=%h exp=%h", nm, oq, eq);
    end
    if (orr !== er) begin
      bad++; $display("FAIL %s_rem got=%h exp=%h", nm, orr, er);
    end
    if (odz !== edz) begin
      bad++; $display("FAIL %s_dbz got=%b exp=%b", nm, odz, edz);
    end
    if (olat !== 17) begin
      bad++; $display("FAIL %s_lat got=%0d exp=17", nm, olat);
    end
  endtask

  task automatic test_signed();
    run(16, 64'hFF9C, 64'h0007, 1'b1, oq, orr, odz, olat);
    check16("sgn_a", SEN ? 64'hFFF2 : 64'h2484,
            SEN ? 64'hFFFE : 64'h0000, 1'b0);
    run(16, 64'h0064, 64'hFFF9, 1'b1, oq, orr, odz, olat);
    check16("sgn_b", SEN ? 64'hFFF2 : 64'h0000,
            SEN ? 64'h0002 : 64'h0064, 1'b0);
    run(16, 64'hFFF9, 64'hFFFE, 1'b1, oq, orr, odz, olat);
    check16("sgn_c", SEN ? 64'h0003 : 64'h0000,
            SEN ? 64'hFFFF : 64'hFFF9, 1'b0);
  endtask

  task automatic test_div_zero();
    run(16, 64'd1234, 64'd0, 1'b0, oq, orr, odz, olat);
    check16("dz_u", 64'hFFFF, 64'd1234, 1'b1);
    run(16, 64'd9, 64'd3, 1'b0, oq, orr, odz, olat);
    check16("dz_clr", 64'd3, 64'd0, 1'b0);
    run(16, 64'hFFFB, 64'd0, 1'b1, oq, orr, odz, olat);
    check16("dz_s", 64'hFFFF, 64'hFFFB, 1'b1);
  endtask

  task automatic test_overflow();
    run(16, 64'h8000, 64'hFFFF, 1'b1, oq, orr, odz, olat);
    check16("ovf", SEN ? 64'h8000 : 64'h0000,
            SEN ? 64'h0000 : 64'h8000, 1'b0);
    run(16, 64'hFFFF, 64'h0001, 1'b0, oq, orr, odz, olat);
    check16("max_u", 64'hFFFF, 64'h0000, 1'b0);
  endtask

  task automatic test_hold_start();
    int lat;
    @(negedge clk);
    drive(16, 1'b1, 1'b0, 64'd200, 64'd9);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        b16.dividend = 16'd50;
        b16.divisor = 16'd5;
      end
      if (b16.done === 1'b1) begin
        lat = k;
        b16.start = 1'b0;
        break;
      end
    end
    total += 3;
    if (lat !== 17) begin
      bad++; $display("FAIL hold_lat got=%0d exp=17", lat);
    end
    if (b16.quot !== 16'd22) begin
      bad++; $display("FAIL hold_quot got=%0d exp=22", b16.quot);
    end
    if (b16.rem !== 16'd2) begin
      bad++; $display("FAIL hold_rem got=%0d exp=2", b16.rem);
    end
    @(negedge clk);
    total++;
    if (b16.busy !== 1'b0) begin
      bad++; $display("FAIL hold_idle got=%b exp=0", b16.busy);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    run(16, 64'd100, 64'd7, 1'b0, oq, orr, odz, olat);
    check16("b2b_a", 64'd14, 64'd2, 1'b0);
    drive(16, 1'b1, 1'b0, 64'd45, 64'd6);
    gap = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) b16.start = 1'b0;
      if (b16.done === 1'b1) begin
        gap = k + 1;
        break;
      end
    end
    total += 3;
    if (gap !== 18) begin
      bad++; $display("FAIL b2b_gap got=%0d exp=18", gap);
    end
    if (b16.quot !== 16'd7) begin
      bad++; $display("FAIL b2b_quot got=%0d exp=7", b16.quot);
    end
    if (b16.rem !== 16'd3) begin
      bad++; $display("FAIL b2b_rem got=%0d exp=3", b16.rem);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    drive(16, 1'b1, 1'b0, 64'd1000, 64'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) b16.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total += 4;
    if (b16.busy !== 1'b0) begin
      bad++; $display("FAIL abort_busy got=%b exp=0", b16.busy);
    end
    if (b16.done !== 1'b0) begin
      bad++; $display("FAIL abort_done got=%b exp=0", b16.done);
    end
    if (b16.quot !== 16'd0) begin
      bad++; $display("FAIL abort_quot got=%h exp=0", b16.quot);
    end
    if (b16.rem !== 16'd0) begin
      bad++; $display("FAIL abort_rem got=%h exp=0", b16.rem);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (b16.done === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL abort_ghost_done got=%b exp=0", seen);
    end
    run(16, 64'd81, 64'd9, 1'b0, oq, orr, odz, olat);
    check16("after_abort", 64'd9, 64'd0, 1'b0);
  endtask

  task automatic test_random(input int w);
    logic [63:0] m, a, b, eq, er;
    logic s, edz;
    m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom} & m;
      b = {$urandom, $urandom} & m;
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: b = m;
        2: b = 64'd1;
        3: a = 64'd1 << (w - 1);
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      ref_div(w, a, b, s, eq, er, edz);
      run(w, a, b, s, oq, orr, odz, olat);
      total++;
      if (oq !== eq || orr !== er || odz !== edz || olat !== w + 1) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h s=%b got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                 w, a, b, s, oq, orr, odz, olat, eq, er, edz, w + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_hold_start();
    test_back_to_back();
    test_reset_abort();
    test_random(8);
    test_random(32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
